pkt_ingress: RTL and testbench

PKT_INGRESS -- requirements
Module: pkt_ingress

---
 rtl/pkt_ingress.sv | 138 +++++++++++++
 tb/tb_pkt_ingress.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pkt_ingress.sv
// ============================================================================
// pkt_ingress : collects a byte stream into a 128-byte packet image for a core.
// Option      : PKT_INGRESS_OVERSIZE_DROP_EN discards oversize packets (else truncates).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pkt_ingress (
    input  logic          clock,
    input  logic          nrst,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    input  logic          core_done,
    output logic [1023:0] pkt_data,
    output logic [7:0]    pkt_len,
    output logic          pkt_valid,
    output logic          core_start,
    output logic          pkt_trunc,
    output logic          pkt_drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_t;

    localparam logic [7:0] C_LAST_IDX = 8'd127;

    state_t     r_state;
    state_t     w_next;
    logic       w_accept;
    logic       w_wr_en;
    logic       w_clear;
    logic       w_set_trunc;
    logic [9:0] w_idx;
`ifdef PKT_INGRESS_OVERSIZE_DROP_EN
    logic       w_drop;
`endif

    assign s_ready   = (r_state != READY);
    assign pkt_valid = (r_state == READY);
    assign w_accept  = s_valid & s_ready;
    assign w_idx     = {pkt_len[6:0], 3'b000};

    always_comb begin
        w_next      = r_state;
        w_wr_en     = 1'b0;
        w_clear     = 1'b0;
        w_set_trunc = 1'b0;
`ifdef PKT_INGRESS_OVERSIZE_DROP_EN
        w_drop      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    w_next  = s_last ? READY : FILL;
                end
            end
            FILL: begin
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    // last byte wins over the buffer-full transition
                    if (s_last)
                        w_next = READY;
                    else if (pkt_len == C_LAST_IDX)
                        w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_accept && s_last) begin
`ifdef PKT_INGRESS_OVERSIZE_DROP_EN
                    w_next  = IDLE;
                    w_clear = 1'b1;
                    w_drop  = 1'b1;
`else
                    w_next      = READY;
                    w_set_trunc = 1'b1;
`endif
                end
            end
            READY: begin
                if (core_done) begin
                    w_next  = IDLE;
                    w_clear = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            pkt_data   <= '0;
            pkt_len    <= 8'd0;
            core_start <= 1'b0;
            pkt_trunc  <= 1'b0;
        end else begin
            core_start <= (w_next == READY) && (r_state != READY);
            if (w_clear) begin
                pkt_data <= '0;
                pkt_len  <= 8'd0;
            end else if (w_wr_en) begin
                pkt_data[w_idx +: 8] <= s_data;
                pkt_len              <= pkt_len + 8'd1;
            end
            if (w_clear)
                pkt_trunc <= 1'b0;
            else if (w_set_trunc)
                pkt_trunc <= 1'b1;
        end
    end

`ifdef PKT_INGRESS_OVERSIZE_DROP_EN
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst)
            pkt_drop <= 1'b0;
        else
            pkt_drop <= w_drop;
    end
`else
    assign pkt_drop = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pkt_ingress.sv
// ============================================================================
// tb_pkt_ingress : directed self-checking bench for pkt_ingress.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_pkt_ingress;

    logic          clock;
    logic          nrst;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          core_done;
    logic [1023:0] pkt_data;
    logic [7:0]    pkt_len;
    logic          pkt_valid;
    logic          core_start;
    logic          pkt_trunc;
    logic          pkt_drop;

    int n_cmp = 0;
    int n_err = 0;
    logic [1023:0] exp_img;

    pkt_ingress dut (
        .clock      (clock),
        .nrst       (nrst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .core_done  (core_done),
        .pkt_data   (pkt_data),
        .pkt_len    (pkt_len),
        .pkt_valid  (pkt_valid),
        .core_start (core_start),
        .pkt_trunc  (pkt_trunc),
        .pkt_drop   (pkt_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one byte and hold it until it is accepted (bounded wait).
    task automatic push(input logic [7:0] d, input logic last);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (!s_ready) check("push_ready_timeout", {63'd0, s_ready}, 64'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic release_core();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic check_img(input string tag);
        for (int k = 0; k < 16; k++)
            check(tag, pkt_data[64*k +: 64], exp_img[64*k +: 64]);
    endtask

    initial begin
        nrst = 1'b0; s_data = 8'd0; s_valid = 1'b0; s_last = 1'b0; core_done = 1'b0;
        tick(); tick();
        check("rst_valid", {63'd0, pkt_valid}, 64'd0);
        check("rst_len", {56'd0, pkt_len}, 64'd0);
        check("rst_start", {63'd0, core_start}, 64'd0);
        check("rst_trunc", {63'd0, pkt_trunc}, 64'd0);
        check("rst_drop", {63'd0, pkt_drop}, 64'd0);
        check("rst_data_zero", {63'd0, |pkt_data}, 64'd0);
        nrst = 1'b1;
        tick();
        check("rst_ready", {63'd0, s_ready}, 64'd1);

        // 4-byte packet
        push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b1);
        check("p4_valid", {63'd0, pkt_valid}, 64'd1);
        check("p4_start", {63'd0, core_start}, 64'd1);
        check("p4_len", {56'd0, pkt_len}, 64'd4);
        check("p4_data_lo", {32'd0, pkt_data[31:0]}, 64'h44332211);
        check("p4_data_hi", {63'd0, |pkt_data[1023:32]}, 64'd0);
        check("p4_sready", {63'd0, s_ready}, 64'd0);

        // second packet offered while READY is stalled
        s_valid = 1'b1; s_data = 8'h55; s_last = 1'b1;
        tick();
        check("p4_start_once", {63'd0, core_start}, 64'd0);
        tick(); tick();
        check("stall_sready", {63'd0, s_ready}, 64'd0);
        check("stall_valid", {63'd0, pkt_valid}, 64'd1);
        check("stall_len", {56'd0, pkt_len}, 64'd4);
        check("stall_data", {32'd0, pkt_data[31:0]}, 64'h44332211);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("clr_valid", {63'd0, pkt_valid}, 64'd0);
        check("clr_len", {56'd0, pkt_len}, 64'd0);
        check("clr_data", {63'd0, |pkt_data}, 64'd0);
        check("clr_sready", {63'd0, s_ready}, 64'd1);
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        check("p1_valid", {63'd0, pkt_valid}, 64'd1);
        check("p1_len", {56'd0, pkt_len}, 64'd1);
        check("p1_data", {32'd0, pkt_data[31:0]}, 64'h00000055);
        release_core();

        // core_done ignored in IDLE and FILL
        release_core();
        check("cd_idle_len", {56'd0, pkt_len}, 64'd0);
        check("cd_idle_sready", {63'd0, s_ready}, 64'd1);
        push(8'hAA, 1'b0); push(8'hBB, 1'b0);
        release_core();
        check("cd_fill_len", {56'd0, pkt_len}, 64'd2);
        check("cd_fill_valid", {63'd0, pkt_valid}, 64'd0);
        check("cd_fill_data", {32'd0, pkt_data[31:0]}, 64'h0000BBAA);
        push(8'hCC, 1'b1);
        check("p3_len", {56'd0, pkt_len}, 64'd3);
        check("p3_data", {32'd0, pkt_data[31:0]}, 64'h00CCBBAA);
        release_core();

        // exactly 128 bytes, last on the final byte
        exp_img = '0;
        for (int i = 0; i < 128; i++) begin
            exp_img[8*i +: 8] = 8'((i * 7 + 3) & 8'hFF);
            push(8'((i * 7 + 3) & 8'hFF), (i == 127));
        end
        check("p128_valid", {63'd0, pkt_valid}, 64'd1);
        check("p128_start", {63'd0, core_start}, 64'd1);
        check("p128_len", {56'd0, pkt_len}, 64'd128);
        check("p128_trunc", {63'd0, pkt_trunc}, 64'd0);
        check_img("p128_img");
        release_core();

        // 130 bytes: overflow handling
        exp_img = '0;
        for (int i = 0; i < 128; i++) begin
            exp_img[8*i +: 8] = 8'(i) ^ 8'h5A;
            push(8'(i) ^ 8'h5A, 1'b0);
        end
        check("drain_sready", {63'd0, s_ready}, 64'd1);
        check("drain_valid", {63'd0, pkt_valid}, 64'd0);
        check("drain_len", {56'd0, pkt_len}, 64'd128);
        push(8'hE1, 1'b0);
        check("drain_len2", {56'd0, pkt_len}, 64'd128);
        push(8'hE2, 1'b1);
`ifdef PKT_INGRESS_OVERSIZE_DROP_EN
        check("drop_pulse", {63'd0, pkt_drop}, 64'd1);
        check("drop_valid", {63'd0, pkt_valid}, 64'd0);
        check("drop_len", {56'd0, pkt_len}, 64'd0);
        check("drop_trunc", {63'd0, pkt_trunc}, 64'd0);
        check("drop_sready", {63'd0, s_ready}, 64'd1);
        tick();
        check("drop_once", {63'd0, pkt_drop}, 64'd0);
        check("drop_valid2", {63'd0, pkt_valid}, 64'd0);
`else
        check("trunc_valid", {63'd0, pkt_valid}, 64'd1);
        check("trunc_start", {63'd0, core_start}, 64'd1);
        check("trunc_len", {56'd0, pkt_len}, 64'd128);
        check("trunc_flag", {63'd0, pkt_trunc}, 64'd1);
        check("trunc_drop", {63'd0, pkt_drop}, 64'd0);
        check_img("trunc_img");
        release_core();
        check("trunc_clr", {63'd0, pkt_trunc}, 64'd0);
`endif

        // asynchronous reset mid-FILL
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0);
        #2 nrst = 1'b0;
        #1;
        check("arst_len", {56'd0, pkt_len}, 64'd0);
        check("arst_data", {63'd0, |pkt_data}, 64'd0);
        check("arst_valid", {63'd0, pkt_valid}, 64'd0);
        check("arst_start", {63'd0, core_start}, 64'd0);
        tick();
        nrst = 1'b1;
        tick();
        push(8'h77, 1'b0); push(8'h88, 1'b1);
        check("post_rst_len", {56'd0, pkt_len}, 64'd2);
        check("post_rst_data", {32'd0, pkt_data[31:0]}, 64'h00008877);
        check("post_rst_valid", {63'd0, pkt_valid}, 64'd1);
        release_core();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
